// File: rtl/ntt_unloader.sv
// Captures the ntt core's 8x32 coefficient bank and streams it out one coefficient per cycle, optionally frozen to [0,Q).
// First coefficient is valid right after the capture edge; o_valid/o_data hold while i_ready is low, and an early bank is dropped.
module ntt_unloader #(
  parameter int KYBER_Q = 3329,
  parameter int FREEZE  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [0:7][0:31][15:0]  i_data,
  output logic                    o_in_ready,
  output logic                    o_drop,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [15:0]      o_data,
  output logic [7:0]              o_index,
  output logic                    o_last
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam logic signed [16:0] Q17 = 17'(KYBER_Q);
  localparam logic [15:0]        Q16 = 16'(KYBER_Q);

  state_e                    state_q, state_d;
  logic [7:0]                idx_q, idx_d;
  logic                      drop_q, drop_d;
  logic [0:7][0:31][15:0]    bank_q, bank_d;

  logic                      streaming;
  logic                      at_last;
  logic                      capture;
  logic [15:0]               coef;
  logic signed [16:0]        coef_x;
  logic [15:0]               coef_frz;

  assign streaming  = (state_q == STREAM);
  assign at_last    = (idx_q == 8'd255);
  // Ready can reopen during the final beat so a new bank follows with no bubble.
  assign o_in_ready = !streaming || (at_last && i_ready);
  assign capture    = i_valid && o_in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = i_valid && !o_in_ready;
    bank_d  = capture ? i_data : bank_q;
    if (!streaming) begin
      if (i_valid) begin
        state_d = STREAM;
        idx_d   = 8'd0;
      end
    end else if (i_ready) begin
      if (!at_last) begin
        idx_d = idx_q + 8'd1;
      end else begin
        state_d = i_valid ? STREAM : IDLE;
        idx_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Bank contents are don't-care after reset, so no reset term is needed.
  always_ff @(posedge i_clk) begin
    bank_q <= bank_d;
  end

  // Range checks in 17 bits; the final sum always lands in [0,Q) so 16 bits hold it.
  always_comb begin
    coef   = bank_q[idx_q[7:5]][idx_q[4:0]];
    coef_x = {coef[15], coef};
    if (coef_x[16]) begin
      coef_frz = coef + Q16;
    end else if (coef_x >= Q17) begin
      coef_frz = coef - Q16;
    end else begin
      coef_frz = coef;
    end
  end

  always_comb begin
    o_valid = streaming;
    o_index = idx_q;
    o_last  = streaming && at_last;
    o_drop  = drop_q;
    o_data  = '0;
    if (streaming) begin
      o_data = (FREEZE != 0) ? $signed(coef_frz) : $signed(coef);
    end
  end

endmodule

// File: doc/ntt_unloader.md
Name: ntt_unloader

Overview:
- Output-side counterpart of the ntt core's serial loader.
- Captures the ntt core's parallel 8x32 coefficient bank when o_valid pulses.
- Streams the 256 coefficients out one per cycle, in natural order, with a valid/ready handshake.
- Optionally freezes each coefficient to canonical range [0, KYBER_Q) so downstream packing and compare logic see unique values.

Parameters:
- KYBER_Q, 3329, modulus used by the freeze stage.
- FREEZE, 1, 1 = output canonical [0,Q); 0 = pass the signed value through unchanged.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  single-cycle pulse: bank on i_data is valid (driven by ntt o_valid).
- i_data  in  signed 16 x [0:7][0:31]  coefficient bank from the ntt core.
- o_in_ready  out  1  combinational: a bank offered this cycle will be captured.
- o_drop  out  1  one-cycle pulse: i_valid arrived while o_in_ready=0; that bank is discarded.
- o_valid  out  1  o_data holds a valid coefficient.
- i_ready  in  1  downstream accepts; a handshake occurs when o_valid & i_ready.
- o_data  out  signed 16  current coefficient, frozen if FREEZE=1.
- o_index  out  8  index of the current coefficient, 32*row + col.
- o_last  out  1  high with o_valid when o_index==255.

Behaviour:
- Reset (async, i_rst_n=0) forces:
  - state IDLE
  - o_valid=0, o_data=0, o_index=0, o_last=0, o_drop=0
  - bank contents don't-care
- Reset mid-stream aborts immediately; the remaining coefficients are lost and no o_last is emitted.
- States:
  - IDLE: o_valid=0; o_in_ready=1. On i_valid, capture the entire bank into an internal 256x16 register, set idx=0, go to STREAM.
  - STREAM: o_valid=1. On handshake with idx<255, idx++. On handshake with idx==255, go to IDLE, unless i_valid is high that same cycle, in which case capture the new bank, set idx=0 and stay in STREAM.
- o_in_ready = (state==IDLE) | (state==STREAM & idx==255 & i_ready).
- i_valid with o_in_ready=0: bank is not captured; o_drop is registered high for exactly the next cycle; streaming is unaffected.
- Latency: i_valid sampled at edge k leaves o_valid=1 with o_index=0 from just after edge k. Throughput is 1 coefficient/cycle with i_ready held high, so 256 cycles per bank.
- Back-to-back banks: o_valid never drops between the two banks; o_index wraps 255 -> 0.
- o_data, o_index and o_last are combinational from the registered bank, idx and state, and hold stable while o_valid & ~i_ready.
- Output order is row-major: o_index n = i_data[n/32][n%32] as captured.
- Freeze, FREEZE=1:
  - Defined input range is [-Q, 2Q).
  - x<0 -> x+Q; x>=Q -> x-Q; else x.
  - Computed in 17-bit signed; the result always fits in [0, Q-1].
  - Inputs outside [-Q, 2Q) give an unspecified result.
- FREEZE=0: o_data = stored value, bit-exact.
- i_data is sampled only on the capture edge; changes on i_data at other times have no effect.

Test Plan:
- Ramp: bank[r][c] = (32r+c) % 3329, i_ready=1 -> 256 beats, o_data 0..255 in order; o_last only at o_index 255; o_valid low after the final handshake.
- Backpressure: i_ready toggles 1,0,0,1 repeating with bank value 1000 at idx 5 -> o_data/o_index hold through the stalls; every coefficient is emitted exactly once; 512 cycles total.
- Freeze: entries -1, -3329, 3329, 6657, 0, 3328 with FREEZE=1 -> 3328, 0, 0, 3328, 0, 3328; with FREEZE=0 -> values unchanged.
- Back-to-back: second i_valid in the same cycle as the final handshake of bank A -> captured; next beat is bank B index 0; o_valid continuous; o_drop=0.
- Drop: i_valid at idx 100 of an active stream -> o_drop high for 1 cycle; bank A continues unchanged to 255, then IDLE.
- Async reset: assert i_rst_n=0 mid-cycle at idx 50 -> o_valid=0 and o_index=0 immediately, without waiting for a clock; a new bank after release streams from index 0.
